// File: rtl/bdi_pkg.sv
// Shared widths and encoding codes for the BDI decompressor.
package bdi_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned WORDS    = 8;
    localparam int unsigned LINE_W   = WORD_W * WORDS;
    localparam int unsigned DELTA1_W = 8;
    localparam int unsigned DELTA2_W = 16;

    typedef logic [2:0] enc_t;

    localparam enc_t ENC_ZEROS  = 3'd0;
    localparam enc_t ENC_REP    = 3'd1;
    localparam enc_t ENC_B4D1   = 3'd2;
    localparam enc_t ENC_B4D2   = 3'd3;
    localparam enc_t ENC_UNCOMP = 3'd4;

endpackage

// File: rtl/bdi_word_decode.sv
// One BDI word: sign-extend an 8- or 16-bit delta and optionally add the base.
module bdi_word_decode
    import bdi_pkg::*;
(
    input  logic [WORD_W-1:0]   base,
    input  logic [DELTA2_W-1:0] delta,
    input  logic                wide,
    input  logic                sel,
    output logic [WORD_W-1:0]   word_c
);

    logic [WORD_W-1:0] delta_ext;

    // wide=0 uses only the low byte of the delta field
    always_comb begin
        delta_ext = '0;
        if (wide) begin
            delta_ext = {{(WORD_W - DELTA2_W){delta[DELTA2_W-1]}}, delta};
        end else begin
            delta_ext = {{(WORD_W - DELTA1_W){delta[DELTA1_W-1]}}, delta[DELTA1_W-1:0]};
        end
    end

    // Wrap-around on the add is intentional and silent
    assign word_c = sel ? (base + delta_ext) : delta_ext;

endmodule

// File: rtl/decompressor_unit.sv
// BDI cache-line decompressor: combinational decode into a single output register.
module decompressor_unit
    import bdi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [2:0]        enc,
    input  logic [WORDS-1:0]  mask,
    input  logic [LINE_W-1:0] comp_in,
    output logic [LINE_W-1:0] DecompCache,
    output logic              valid
);

    logic [WORD_W-1:0] base_c;
    logic              wide_c;
    logic [LINE_W-1:0] bdi_line_c;
    logic [LINE_W-1:0] line_c;

    assign base_c = comp_in[WORD_W-1:0];
    assign wide_c = (enc == ENC_B4D2);

    for (genvar i = 0; i < WORDS; i++) begin : g_word
        logic [DELTA2_W-1:0] delta_c;

        assign delta_c = wide_c
                       ? comp_in[WORD_W + DELTA2_W*i +: DELTA2_W]
                       : DELTA2_W'(comp_in[WORD_W + DELTA1_W*i +: DELTA1_W]);

        bdi_word_decode u_word (
            .base   (base_c),
            .delta  (delta_c),
            .wide   (wide_c),
            .sel    (mask[i]),
            .word_c (bdi_line_c[WORD_W*i +: WORD_W])
        );
    end

    // Encoding select; reserved codes fall through to an all-zero line
    always_comb begin
        line_c = '0;
        case (enc)
            ENC_ZEROS:  line_c = '0;
            ENC_REP:    line_c = {WORDS{base_c}};
            ENC_B4D1,
            ENC_B4D2:   line_c = bdi_line_c;
            ENC_UNCOMP: line_c = comp_in;
            default:    line_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DecompCache <= '0;
            valid       <= 1'b0;
        end else if (load) begin
            DecompCache <= line_c;
            valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decompressor_unit.sv
// Self-checking bench for decompressor_unit against a behavioural BDI model.
module tb_decompressor_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [2:0]   enc;
    logic [7:0]   mask;
    logic [255:0] comp_in;
    logic [255:0] DecompCache;
    logic         valid;

    int checks   = 0;
    int failures = 0;

    decompressor_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .enc         (enc),
        .mask        (mask),
        .comp_in     (comp_in),
        .DecompCache (DecompCache),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    // Reference decode from the encoding rules, using integer arithmetic
    function automatic logic [255:0] model(input logic [2:0] e, input logic [7:0] m,
                                           input logic [255:0] c);
        logic [255:0] r;
        longint base, d, w;
        r = '0;
        base = longint'({32'd0, c[31:0]});
        case (e)
            3'd1: for (int i = 0; i < 8; i++) r[32*i +: 32] = c[31:0];
            3'd2, 3'd3: begin
                for (int i = 0; i < 8; i++) begin
                    if (e == 3'd2) begin
                        d = longint'({56'd0, c[32 + 8*i +: 8]});
                        if (d >= 128) d = d - 256;
                    end else begin
                        d = longint'({48'd0, c[32 + 16*i +: 16]});
                        if (d >= 32768) d = d - 65536;
                    end
                    w = m[i] ? (base + d) : d;
                    r[32*i +: 32] = w[31:0];
                end
            end
            3'd4: r = c;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic drive_load(input logic [2:0] e, input logic [7:0] m, input logic [255:0] c);
        @(negedge clk);
        load = 1'b1; enc = e; mask = m; comp_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [255:0] exp_line, input logic exp_valid);
        checks++;
        if (DecompCache !== exp_line || valid !== exp_valid) begin
            failures++;
            $display("FAIL %s: got line=%h valid=%b, expected line=%h valid=%b",
                     name, DecompCache, valid, exp_line, exp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; enc = '0; mask = '0; comp_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (DecompCache !== '0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset: got line=%h valid=%b, expected 0/0", DecompCache, valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_b4d1();
        logic [255:0] c, e;
        c = '0; e = '0;
        c[31:0] = 32'h1000_0000;
        for (int i = 0; i < 8; i++) begin
            c[32 + 8*i +: 8] = 8'(i);
            e[32*i +: 32]    = 32'h1000_0000 + 32'(i);
        end
        drive_load(3'd2, 8'hFF, c);
        check_out("b4d1_seq", e, 1'b1);
        idle();
    endtask

    task automatic test_b4d2_mixed();
        logic [255:0] c, e;
        c = '0;
        c[31:0] = 32'hABCD_0000;
        for (int i = 0; i < 8; i++) c[32 + 16*i +: 16] = (i % 2 == 0) ? 16'h0010 : 16'hFFFF;
        e = {32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0010,
             32'hABCC_FFFF, 32'hABCD_0010, 32'hABCC_FFFF, 32'hABCD_0010};
        drive_load(3'd3, 8'h0F, c);
        check_out("b4d2_mixed", e, 1'b1);
        idle();
    endtask

    task automatic test_wrap();
        logic [255:0] c;
        c = '0;
        c[31:0]  = 32'hFFFF_FFFF;
        c[39:32] = 8'h01;
        drive_load(3'd2, 8'h01, c);
        checks++;
        if (DecompCache[31:0] !== 32'h0000_0000 || valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap: got word0=%h valid=%b, expected 00000000/1", DecompCache[31:0], valid);
        end
        // Upper bits beyond the B4D1 payload are ignored, words 1..7 are zero deltas
        check_out("wrap_line", 256'h0, 1'b1);
        idle();
    endtask

    task automatic test_rep_zeros_uncomp();
        logic [255:0] c;
        c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'hDEAD_BEEF};
        drive_load(3'd1, 8'h5A, c);
        check_out("rep", {8{32'hDEAD_BEEF}}, 1'b1);
        drive_load(3'd0, 8'hFF, c);
        check_out("zeros", 256'h0, 1'b1);
        c = {8{32'h1234_5678 ^ $urandom}};
        drive_load(3'd4, 8'h33, c);
        check_out("uncomp", c, 1'b1);
        drive_load(3'd6, 8'hFF, c);
        check_out("reserved6", 256'h0, 1'b1);
        idle();
    endtask

    task automatic test_back_to_back();
        logic [2:0]   e;
        logic [7:0]   m;
        logic [255:0] c;
        for (int n = 0; n < 60; n++) begin
            e = 3'($urandom_range(0, 7));
            m = 8'($urandom);
            c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            drive_load(e, m, c);
            check_out($sformatf("b2b_%0d_enc%0d", n, e), model(e, m, c), 1'b1);
        end
        idle();
    endtask

    task automatic test_hold();
        logic [255:0] c, held;
        c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        drive_load(3'd3, 8'hA5, c);
        held = model(3'd3, 8'hA5, c);
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enc = 3'($urandom); mask = 8'($urandom);
            comp_in = {8{$urandom}};
            @(posedge clk);
            #1;
            check_out($sformatf("hold_%0d", k), held, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [255:0] c;
        c = {8{32'hCAFE_F00D}};
        drive_load(3'd4, 8'h00, c);
        check_out("pre_async", c, 1'b1);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_clear", 256'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_load(3'd1, 8'h00, {224'h0, 32'h0BAD_F00D});
        check_out("post_reset_load", {8{32'h0BAD_F00D}}, 1'b1);
        idle();
    endtask

    initial begin
        test_reset();
        test_b4d1();
        test_b4d2_mixed();
        test_wrap();
        test_rep_zeros_uncomp();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decompressor_unit.md
Name: decompressor_unit

Overview:
- Base-Delta-Immediate (BDI) cache-line decompressor with a dynamic 4-byte base.
- Expands one compressed line (base, deltas, per-word base-select mask, encoding) into a full 256-bit line of eight 32-bit words.
- Sits between the compressed cache data array and the line-fill/read path; one line per cycle, fully pipelined.

Parameters:
- WORD_W, 32, width of one decompressed word and of the base.
- WORDS, 8, words per line.
- LINE_W, 256, decompressed line width (WORD_W*WORDS).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  compressed line present this cycle.
- enc  input  3  encoding of comp_in.
- mask  input  8  per-word select: 1 = base+delta, 0 = immediate (zero base).
- comp_in  input  256  compressed payload, LSB-aligned.
- DecompCache  output  256  decompressed line; word i at [32i+31:32i].
- valid  output  1  DecompCache holds a decoded line.

Behaviour:
- Reset (rst_n low, asynchronous): DecompCache = 0, valid = 0; both held while rst_n is low.
- Latency 1: on a rising edge with load=1, DecompCache <= decode(enc, mask, comp_in) and valid <= 1.
- On a rising edge with load=0, DecompCache and valid hold their values.
- Reset asserted mid-stream clears both outputs immediately; the first load after release decodes normally.
- Encodings:
  - 0 ZEROS: all words 0.
  - 1 REP: every word = comp_in[31:0].
  - 2 B4D1: base = comp_in[31:0]; delta_i = sign-extend of comp_in[32+8i +: 8].
  - 3 B4D2: base = comp_in[31:0]; delta_i = sign-extend of comp_in[32+16i +: 16].
  - 4 UNCOMP: DecompCache = comp_in.
  - 5-7 reserved: decode as ZEROS; valid still set.
- B4D1/B4D2: word_i = mask[i] ? (base + delta_i) mod 2^32 : delta_i. Wrap-around is silent; no overflow flag.
- mask is ignored for ZEROS, REP and UNCOMP.
- comp_in bits beyond the used payload (above 95 for B4D1, above 159 for B4D2) are ignored.
- Decode is purely combinational into the single output register; no back-pressure and no stall.

Decomposition:
- Package bdi_pkg: ENC_ZEROS=0, ENC_REP=1, ENC_B4D1=2, ENC_B4D2=3, ENC_UNCOMP=4; localparams for word width, word count and delta widths; typedef for the 3-bit encoding.
- One sub-module, bdi_word_decode. It takes base, the 16-bit delta field, a delta-size select and a mask bit, and returns one 32-bit word. It is instantiated WORDS times in a generate loop; the top level handles encoding muxing and the output register.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> DecompCache=0, valid=0. Assert rst_n low asynchronously between edges -> both clear immediately.
- B4D1: base 0x1000_0000, deltas 00,01,...,07, mask 0xFF -> words 0x1000_0000..0x1000_0007, valid=1 one edge after load.
- B4D2 mixed: base 0xABCD_0000, deltas 0x0010 and 0xFFFF alternating, mask 0x0F. Required words:
  - words 0-3 (base-relative): 0xABCD_0010, 0xABCC_FFFF, 0xABCD_0010, 0xABCC_FFFF.
  - words 4-7 (immediate): 0x0000_0010, 0xFFFF_FFFF, 0x0000_0010, 0xFFFF_FFFF.
- Wrap: B4D1, base 0xFFFF_FFFF, delta 0x01, mask 0x01 -> word0 = 0x0000_0000.
- REP, ZEROS, UNCOMP:
  - REP with comp_in[31:0]=0xDEAD_BEEF -> all eight words 0xDEAD_BEEF.
  - ZEROS -> 0.
  - UNCOMP with an arbitrary pattern -> identical output.
  - enc=6 -> 0 with valid=1.
- Hold/back-to-back: loads on consecutive cycles -> each result appears one cycle later. With load=0 for 5 cycles -> output and valid unchanged.
